// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Purpose  : Shared definitions for the node instruction link receiver.
//            Source codes, the default-width {src, instr} entry type and the
//            round-robin ring successor helper.
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

  localparam logic [1:0] SRC_SELF  = 2'b00;
  localparam logic [1:0] SRC_RIGHT = 2'b01;
  localparam logic [1:0] SRC_LEFT  = 2'b10;

  localparam int LINK_WIDTH = 32;

  // One buffered entry at the default link word width.
  typedef struct packed {
    logic [1:0]            src;
    logic [LINK_WIDTH-1:0] instr;
  } link_entry_t;

  // Ring order self -> right -> left -> self. The unused code 2'b11 folds
  // back to self so a corrupted pointer recovers on its own.
  function automatic logic [1:0] next_src(input logic [1:0] src);
    case (src)
      SRC_SELF:  return SRC_RIGHT;
      SRC_RIGHT: return SRC_LEFT;
      default:   return SRC_SELF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo
// Purpose  : Synchronous FIFO with first-word-fall-through head output.
// Ports    : clk, reset_n (sync, active-low)
//            push/wdata  - write an entry (ignored when full with no pop)
//            pop         - drop the head entry (ignored when empty)
//            rdata       - head entry, combinational from storage
//            full/empty/count - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module instr_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != FULL_COUNT) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/link_receiver.sv
`default_nettype none
// ============================================================================
// Module   : link_receiver
// Purpose  : Receiving end of the node instruction link. Round-robin arbitrates
//            the self/right/left requesters, tags each captured word with its
//            source and buffers it for the local consumer.
// Ports    : check_*/instr_* - requester word pending / word
//            ack_*           - one-cycle capture pulse per requester
//            out_valid/out_instr/out_src/out_ready - consumer handshake
//            full/empty/count - buffer occupancy
// Revision : 1.0 - initial release
// ============================================================================
module link_receiver
  import link_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             check_self,
  input  logic             check_right,
  input  logic             check_left,
  input  logic [WIDTH-1:0] instr_self,
  input  logic [WIDTH-1:0] instr_right,
  input  logic [WIDTH-1:0] instr_left,
  output logic             ack_self,
  output logic             ack_right,
  output logic             ack_left,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  // Bit order of per-source vectors matches the source code: [0] self,
  // [1] right, [2] left.
  logic [2:0]       ack_q, ack_d;
  logic [1:0]       rr_q, rr_d;
  logic [2:0]       eligible;
  logic             pop, space, found, capture;
  logic [1:0]       winner, cand;
  logic [WIDTH-1:0] win_word;
  logic [WIDTH+1:0] fifo_wdata, fifo_rdata;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign space     = !full || pop;

  // A requester still sees its ack in the cycle after capture and keeps its
  // check high; masking it here prevents taking the same word twice.
  assign eligible = {check_left, check_right, check_self} & ~ack_q;

  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    cand   = rr_q;
    for (int i = 0; i < 3; i++) begin
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = next_src(cand);
    end
  end

  assign capture = found && space;

  always_comb begin
    case (winner)
      SRC_RIGHT: win_word = instr_right;
      SRC_LEFT:  win_word = instr_left;
      default:   win_word = instr_self;
    endcase
  end

  always_comb begin
    ack_d = '0;
    rr_d  = rr_q;
    if (capture) begin
      ack_d = 3'b001 << winner;
      rr_d  = next_src(winner);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q <= '0;
      rr_q  <= SRC_SELF;
    end else begin
      ack_q <= ack_d;
      rr_q  <= rr_d;
    end
  end

  assign fifo_wdata = {winner, win_word};

  instr_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (capture),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign out_instr = fifo_rdata[WIDTH-1:0];
  assign out_src   = fifo_rdata[WIDTH+1:WIDTH];
  assign ack_self  = ack_q[0];
  assign ack_right = ack_q[1];
  assign ack_left  = ack_q[2];

endmodule
`default_nettype wire

// File: doc/link_receiver.md
Name: link_receiver

Overview:
- Receiving end of the node instruction link. Accepts instruction words from three requesters (self, right neighbour, left neighbour). Each requester holds a check line high with a stable word until it gets an ack.
- Arbitrates round-robin, tags each word with its source and buffers it in a small FIFO.
- Presents words to the local consumer over a valid/ready handshake. Sits between the per-direction senders and the node's instruction decode.

Parameters:
- WIDTH, 32, instruction word width.
- DEPTH, 4, FIFO entries (power of two, at least 2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- check_self  input  1  self requester has a word pending.
- check_right  input  1  right requester has a word pending.
- check_left  input  1  left requester has a word pending.
- instr_self  input  WIDTH  self word; stable while check_self is high.
- instr_right  input  WIDTH  right word.
- instr_left  input  WIDTH  left word.
- ack_self  output  1  one-cycle pulse: self word captured.
- ack_right  output  1  one-cycle pulse: right word captured.
- ack_left  output  1  one-cycle pulse: left word captured.
- out_valid  output  1  FIFO head is valid.
- out_instr  output  WIDTH  FIFO head word.
- out_src  output  2  head source: 00 self, 01 right, 10 left (11 never driven).
- out_ready  input  1  consumer accepts head this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  PTR_W+1  occupied entries.

Behaviour:
- Reset: single clock clk; reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
  - While reset_n is low at an edge: all acks 0, out_valid 0, out_instr 0, out_src 00, count 0, empty 1, full 0, pointers 0, round-robin pointer = self.
  - Reset mid-operation drops buffered words and pending acks. Requesters re-present their words after reset.
- Eligibility: a source is eligible when its check is high and its own ack is not high this cycle. Masking stops a double capture while the requester is still seeing its ack.
- Space: a capture is permitted when the FIFO is not full, or when it is full and out_valid && out_ready in the same cycle (simultaneous pop frees a slot).
- Arbitration: combinational round-robin over the eligible sources, fixed ring order self -> right -> left -> self.
  - Search starts at the round-robin pointer.
  - On a capture, the pointer moves to the source after the winner. No capture leaves the pointer unchanged.
- Capture at edge N:
  - The FIFO writes {winner code, winner word} at the write pointer.
  - The winner's ack is registered high for cycle N+1 only. At most one ack is high in any cycle.
- Pop: out_valid && out_ready at an edge advances the read pointer.
  - out_instr and out_src are the head entry, combinational from the storage array; out_valid = !empty.
  - Pop on empty cannot occur because out_valid is 0.
- Count: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop. Pointers wrap modulo DEPTH.
- Latency:
  - Check high before edge N, FIFO empty, no competitor: out_valid and ack are both high in cycle N+1.
  - Back-to-back captures from different sources are allowed every cycle.
  - The same source can be captured at most every other cycle.
- Full: with no pop, checks are ignored (no ack) until space frees. Requesters keep holding their words.
- Order: FIFO order equals grant order.
- X-safety: a word whose check is low is never captured.

Decomposition:
- Shared package link_pkg: SRC_SELF=2'b00, SRC_RIGHT=2'b01, SRC_LEFT=2'b10, and a typedef for the {src, instr} entry.
- One sub-module, instr_fifo: a synchronous FIFO with push, pop, full, empty and count, parameterised by WIDTH+2 and DEPTH.
- Arbiter, round-robin pointer and ack registers live in link_receiver.

Test Plan:
- Reset, then check_self=1 with instr_self=0xDEADBEEF before edge 1 -> cycle 1: ack_self=1, out_valid=1, out_instr=0xDEADBEEF, out_src=00, count=1. Cycle 2: ack_self=0, no second capture while check_self stays high during the ack cycle.
- All three checks held high (words 0x1, 0x2, 0x3), out_ready=1 -> grants self, right, left, self... ; ack_right at cycle 2, ack_left at cycle 3; out_src sequence 00, 01, 10, 00.
- out_ready=0, right requester presents 0x10..0x14 sequentially -> 4 words captured, full=1, count=4, the fifth check gets no ack. Raising out_ready for one cycle pops 0x10 and captures 0x14 at the same edge, count stays 4.
- Drain test: after filling with 0xA0..0xA3, out_ready=1 -> out_instr 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, then empty=1, out_valid=0. Pointer wrap verified on a second fill.
- reset_n=0 for one edge with count=3 and ack_left pending -> next cycle count=0, empty=1, all acks 0, pointer=self. With all checks high afterwards, first grant is self.
- Random valid/ready stress with scoreboard -> no loss, duplication or reordering relative to grant order; at most one ack per cycle.
